// File: rtl/featuremap_channel_scatter_pkg.sv
// Shared definitions for the conv2d_1 feature-map channel scatter.
// Holds the channel/word geometry, the conv2d_1 frame size and the
// channel-word bank type used by the gather and hold banks.
package featuremap_channel_scatter_pkg;

  localparam int unsigned NCH                   = 8;
  localparam int unsigned DWIDTH                = 32;
  localparam int unsigned CONV2D_1_FRAME_PIXELS = 900;

  typedef logic [DWIDTH-1:0]      word_t;
  typedef word_t [NCH-1:0]        chan_words_t;

endpackage

// File: rtl/featuremap_channel_scatter_if.sv
// Bus bundle between the scatter block and its environment: the upstream
// read-side FIFO handshake, the 8 channel FIFO write ports and frame status.
// master: the scatter block.  slave: upstream FIFO / channel FIFOs / monitor.
interface featuremap_channel_scatter_if
  import featuremap_channel_scatter_pkg::*;
#(
  parameter int unsigned CNT_W = 10
) ();

  word_t            in_rdata;
  logic             in_empty;
  logic             in_rdreq;
  word_t            ff_wdata0, ff_wdata1, ff_wdata2, ff_wdata3;
  word_t            ff_wdata4, ff_wdata5, ff_wdata6, ff_wdata7;
  logic             ff_full0, ff_full1, ff_full2, ff_full3;
  logic             ff_full4, ff_full5, ff_full6, ff_full7;
  logic             ff_wrreq;
  logic             frame_done;
  logic [CNT_W-1:0] pixel_count;

  modport master (
    input  in_rdata, in_empty,
    input  ff_full0, ff_full1, ff_full2, ff_full3,
    input  ff_full4, ff_full5, ff_full6, ff_full7,
    output in_rdreq,
    output ff_wdata0, ff_wdata1, ff_wdata2, ff_wdata3,
    output ff_wdata4, ff_wdata5, ff_wdata6, ff_wdata7,
    output ff_wrreq, frame_done, pixel_count
  );

  modport slave (
    output in_rdata, in_empty,
    output ff_full0, ff_full1, ff_full2, ff_full3,
    output ff_full4, ff_full5, ff_full6, ff_full7,
    input  in_rdreq,
    input  ff_wdata0, ff_wdata1, ff_wdata2, ff_wdata3,
    input  ff_wdata4, ff_wdata5, ff_wdata6, ff_wdata7,
    input  ff_wrreq, frame_done, pixel_count
  );

endinterface

// File: rtl/featuremap_pixel_gather.sv
// Upstream read handshake plus the 8-slot gather bank.
// Ports: clock/reset; in_rdata/in_empty/in_rdreq (normal-mode FIFO read);
// xfer from the top (pixel moves to the hold bank this cycle);
// pix_c = gather bank with the in-flight word merged into its slot;
// pix_done_c = a complete pixel is available this cycle.
module featuremap_pixel_gather
  import featuremap_channel_scatter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  word_t       in_rdata,
  input  logic        in_empty,
  input  logic        xfer,
  output logic        in_rdreq,
  output chan_words_t pix_c,
  output logic        pix_done_c
);

  localparam int unsigned CW = 4;

  logic [CW-1:0] gather_cnt_q, gather_cnt_d;
  logic          rd_pending_q, rd_pending_d;
  chan_words_t   gather_q, gather_d;

  // Read whenever the bank (counting the in-flight word) has room, or the
  // completed pixel leaves this cycle.  Reset blocks reads so nothing is popped.
  always_comb begin
    in_rdreq = reset && !in_empty &&
               (((gather_cnt_q + CW'(rd_pending_q)) < CW'(NCH)) || xfer);
  end

  // The ch7 word may bypass the bank straight into the hold bank, which
  // keeps the sustained rate at one word per cycle.
  always_comb begin
    pix_c = gather_q;
    if (rd_pending_q && (gather_cnt_q < CW'(NCH))) begin
      pix_c[gather_cnt_q[2:0]] = in_rdata;
    end
    pix_done_c = (gather_cnt_q == CW'(NCH)) ||
                 ((gather_cnt_q == CW'(NCH - 1)) && rd_pending_q);
  end

  always_comb begin
    gather_cnt_d = gather_cnt_q;
    gather_d     = gather_q;
    rd_pending_d = in_rdreq;
    if (xfer) begin
      gather_cnt_d = '0;
    end else if (rd_pending_q) begin
      gather_d[gather_cnt_q[2:0]] = in_rdata;
      gather_cnt_d                = gather_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      gather_cnt_q <= '0;
      rd_pending_q <= 1'b0;
      gather_q     <= '0;
    end else begin
      gather_cnt_q <= gather_cnt_d;
      rd_pending_q <= rd_pending_d;
      gather_q     <= gather_d;
    end
  end

endmodule

// File: rtl/featuremap_channel_scatter.sv
// Scatters a channel-interleaved pixel stream into 8 per-channel FIFOs.
// Ports: clock, reset (sync, active-low), bus (master side of
// featuremap_channel_scatter_if).  Holds the hold bank, the common write
// strobe gated by all full flags, and the per-frame pixel counter.
module featuremap_channel_scatter
  import featuremap_channel_scatter_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = CONV2D_1_FRAME_PIXELS
) (
  input  logic                        clock,
  input  logic                        reset,
  featuremap_channel_scatter_if.master bus
);

  localparam int unsigned     CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  chan_words_t      pix_c;
  logic             pix_done_c;
  logic             xfer;
  logic             wr;
  logic             any_full;
  chan_words_t      hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0] pixel_count_q, pixel_count_d;

  featuremap_pixel_gather u_gather (
    .clock      (clock),
    .reset      (reset),
    .in_rdata   (bus.in_rdata),
    .in_empty   (bus.in_empty),
    .xfer       (xfer),
    .in_rdreq   (bus.in_rdreq),
    .pix_c      (pix_c),
    .pix_done_c (pix_done_c)
  );

  // Write only when every channel FIFO has space so channels never skew.
  always_comb begin
    any_full = bus.ff_full0 | bus.ff_full1 | bus.ff_full2 | bus.ff_full3 |
               bus.ff_full4 | bus.ff_full5 | bus.ff_full6 | bus.ff_full7;
    wr       = reset && hold_valid_q && !any_full;
    xfer     = reset && pix_done_c && (!hold_valid_q || wr);
  end

  always_comb begin
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    pixel_count_d = pixel_count_q;
    if (xfer) begin
      hold_d       = pix_c;
      hold_valid_d = 1'b1;
    end else if (wr) begin
      hold_valid_d = 1'b0;
    end
    if (wr) begin
      pixel_count_d = (pixel_count_q == LAST_PIX) ? '0 : pixel_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      pixel_count_q <= '0;
    end else begin
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      pixel_count_q <= pixel_count_d;
    end
  end

  assign bus.ff_wrreq    = wr;
  assign bus.frame_done  = wr && (pixel_count_q == LAST_PIX);
  assign bus.pixel_count = pixel_count_q;
  assign bus.ff_wdata0   = hold_q[0];
  assign bus.ff_wdata1   = hold_q[1];
  assign bus.ff_wdata2   = hold_q[2];
  assign bus.ff_wdata3   = hold_q[3];
  assign bus.ff_wdata4   = hold_q[4];
  assign bus.ff_wdata5   = hold_q[5];
  assign bus.ff_wdata6   = hold_q[6];
  assign bus.ff_wdata7   = hold_q[7];

endmodule

// File: tb/tb_featuremap_channel_scatter.sv
// Scoreboard bench for featuremap_channel_scatter (FRAME_PIXELS=4).
module tb_featuremap_channel_scatter;
  import featuremap_channel_scatter_pkg::*;

  typedef struct {
    chan_words_t pix;
    logic        fd;
    logic [1:0]  pc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  featuremap_channel_scatter_if #(.CNT_W(2)) bus ();

  featuremap_channel_scatter #(.FRAME_PIXELS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  word_t       up_mem [0:255];
  int          up_wr = 0;
  int          up_rd = 0;
  logic        starve = 1'b0;
  logic [7:0]  full = '0;
  exp_t        exp_q [$];
  int          exp_pc = 0;
  int          run = 0;
  int          max_run = 0;
  exp_t        e;
  chan_words_t act;

  assign bus.in_empty = (up_rd == up_wr) || starve;
  assign bus.ff_full0 = full[0];
  assign bus.ff_full1 = full[1];
  assign bus.ff_full2 = full[2];
  assign bus.ff_full3 = full[3];
  assign bus.ff_full4 = full[4];
  assign bus.ff_full5 = full[5];
  assign bus.ff_full6 = full[6];
  assign bus.ff_full7 = full[7];

  task automatic check(input string name, input logic [255:0] a, input logic [255:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, a, x);
    end
  endtask

  function automatic chan_words_t dut_wdata();
    return {bus.ff_wdata7, bus.ff_wdata6, bus.ff_wdata5, bus.ff_wdata4,
            bus.ff_wdata3, bus.ff_wdata2, bus.ff_wdata1, bus.ff_wdata0};
  endfunction

  function automatic chan_words_t seq_pix(input word_t base);
    chan_words_t p;
    for (int i = 0; i < 8; i++) p[i] = base + word_t'(i);
    return p;
  endfunction

  // Upstream normal-mode FIFO: data appears the cycle after the read request.
  initial bus.in_rdata = '0;
  always @(posedge clock) begin
    if (bus.in_rdreq) begin
      check("read_while_empty", 256'(bus.in_empty), 256'(0));
      bus.in_rdata <= up_mem[up_rd[7:0]];
      up_rd        <= up_rd + 1;
    end
  end

  // Monitor: pops an expected pixel on every write strobe.
  always @(negedge clock) begin
    if (reset && bus.ff_wrreq) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 256'(bus.ff_wrreq), 256'(0));
      end else begin
        e   = exp_q.pop_front();
        act = dut_wdata();
        check("pixel_data", 256'(act), 256'(e.pix));
        check("frame_done", 256'(bus.frame_done), 256'(e.fd));
        check("pixel_count_at_wr", 256'(bus.pixel_count), 256'(e.pc));
      end
      check("wr_while_full", 256'(|full), 256'(0));
    end else if (bus.frame_done) begin
      check("stray_frame_done", 256'(bus.frame_done), 256'(0));
    end
    if (bus.in_rdreq) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_word(input word_t w);
    up_mem[up_wr[7:0]] = w;
    up_wr++;
  endtask

  task automatic expect_pixel(input word_t base);
    exp_t x;
    x.pix  = seq_pix(base);
    x.pc   = 2'(exp_pc);
    x.fd   = (exp_pc == 3);
    exp_pc = (exp_pc + 1) % 4;
    exp_q.push_back(x);
  endtask

  task automatic add_pixel(input word_t base);
    for (int i = 0; i < 8; i++) push_word(base + word_t'(i));
    expect_pixel(base);
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      cyc(1);
      budget++;
    end
    check(name, 256'(exp_q.size()), 256'(0));
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    full   = '0;
    starve = 1'b0;
    exp_q.delete();
    exp_pc = 0;
    cyc(2);
    check("rst_rdreq", 256'(bus.in_rdreq), 256'(0));
    check("rst_wrreq", 256'(bus.ff_wrreq), 256'(0));
    check("rst_frame_done", 256'(bus.frame_done), 256'(0));
    check("rst_pixel_count", 256'(bus.pixel_count), 256'(0));
    check("rst_wdata", 256'(dut_wdata()), 256'(0));
    reset = 1'b1;
  endtask

  initial begin
    int rd0;

    // Word order with sustained reads.
    do_reset();
    run = 0; max_run = 0;
    add_pixel(32'h00);
    add_pixel(32'h08);
    drain("order_drain");
    check("rdreq_run", 256'(max_run), 256'(16));

    // Backpressure on channel 3.
    do_reset();
    full[3] = 1'b1;
    rd0 = up_rd;
    add_pixel(32'h00);
    add_pixel(32'h08);
    add_pixel(32'h10);
    cyc(20);
    check("bp_reads", 256'(up_rd - rd0), 256'(16));
    check("bp_hold", 256'(dut_wdata()), 256'(seq_pix(32'h00)));
    check("bp_none_written", 256'(exp_q.size()), 256'(3));
    full[3] = 1'b0;
    drain("bp_drain");

    // Upstream starvation.
    do_reset();
    add_pixel(32'h20);
    add_pixel(32'h28);
    for (int i = 0; i < 60; i++) begin
      starve = ~starve;
      cyc(1);
    end
    starve = 1'b0;
    drain("starve_drain");

    // Frame wrap with FRAME_PIXELS=4.
    do_reset();
    for (int k = 0; k < 5; k++) add_pixel(32'h100 + word_t'(8 * k));
    drain("frame_drain");
    check("frame_count_after", 256'(bus.pixel_count), 256'(1));

    // Reset mid-pixel: partial pixel discarded, next pixel clean.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(32'h30 + word_t'(i));
    cyc(12);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'hA0 + word_t'(i));
    cyc(1);
    rd0 = up_rd;
    cyc(2);
    check("midrst_rdreq", 256'(bus.in_rdreq), 256'(0));
    check("midrst_wrreq", 256'(bus.ff_wrreq), 256'(0));
    check("midrst_wdata", 256'(dut_wdata()), 256'(0));
    check("midrst_no_reads", 256'(up_rd - rd0), 256'(0));
    exp_q.delete();
    exp_pc = 0;
    expect_pixel(32'hA0);
    reset = 1'b1;
    drain("midrst_drain");
    check("midrst_count", 256'(bus.pixel_count), 256'(1));

    // Reset while a write is ready: nothing replayed afterwards.
    do_reset();
    full[0] = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'h50 + word_t'(i));
    cyc(15);
    check("wrrst_hold", 256'(dut_wdata()), 256'(seq_pix(32'h50)));
    reset   = 1'b0;
    full[0] = 1'b0;
    cyc(1);
    check("wrrst_wrreq", 256'(bus.ff_wrreq), 256'(0));
    check("wrrst_wdata", 256'(dut_wdata()), 256'(0));
    check("wrrst_count", 256'(bus.pixel_count), 256'(0));
    reset = 1'b1;
    cyc(20);
    check("wrrst_no_replay_count", 256'(bus.pixel_count), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
